// File: rtl/sa_cache_miss_ctrl.sv
// Miss/eviction sequencer for sa_cache: optional dirty-victim writeback, line refill, one-cycle response.
// Optional watchdog enabled with `define MISS_CTRL_TIMEOUT_EN (sticky o_error, forced empty response).
module sa_cache_miss_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OFFSET_W    = 6,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_miss,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              evict,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [DATA_W-1:0] evict_data,
  output logic [DATA_W-1:0] o_memory_line,
  output logic              o_memory_response,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              o_stall,
  output logic              o_error
);

  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL, RESP, HOLD} state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W)'((1 << OFFSET_W) - 1));

  state_t            state;
  logic [ADDR_W-1:0] line_addr;

  assign o_stall = cache_miss | (state != IDLE);

`ifdef MISS_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_hit;

  // Fires on the cycle that would be the TIMEOUT_CYC-th unacknowledged request cycle.
  assign wd_hit = mem_req && !mem_ack && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign o_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      line_addr         <= '0;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      o_memory_line     <= '0;
      o_memory_response <= 1'b0;
`ifdef MISS_CTRL_TIMEOUT_EN
      wd_cnt            <= '0;
      o_error           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          o_memory_response <= 1'b0;
`ifdef MISS_CTRL_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          if (cache_miss) begin
            line_addr <= miss_addr & LINE_MASK;
            mem_req   <= 1'b1;
            if (evict) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= evict_addr;
              mem_wdata <= evict_data;
            end else begin
              state    <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= miss_addr & LINE_MASK;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            // Drop the request for one gap cycle, then re-issue as a read.
            state    <= REFILL;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= line_addr;
`ifdef MISS_CTRL_TIMEOUT_EN
            wd_cnt   <= '0;
          end else if (wd_hit) begin
            state             <= RESP;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            o_error           <= 1'b1;
            o_memory_line     <= '0;
            o_memory_response <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        REFILL: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            state             <= RESP;
            mem_req           <= 1'b0;
            o_memory_line     <= mem_rdata;
            o_memory_response <= 1'b1;
`ifdef MISS_CTRL_TIMEOUT_EN
          end else if (wd_hit) begin
            state             <= RESP;
            mem_req           <= 1'b0;
            o_error           <= 1'b1;
            o_memory_line     <= '0;
            o_memory_response <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          o_memory_response <= 1'b0;
          state             <= HOLD;
        end
        // Stale miss level from the cache is ignored here.
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// Directed bench for sa_cache_miss_ctrl: reset, clean/dirty miss, stale miss, spurious ack, watchdog.
module tb_sa_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_miss;
  logic [31:0] miss_addr;
  logic        evict;
  logic [31:0] evict_addr;
  logic [31:0] evict_data;
  logic [31:0] o_memory_line;
  logic        o_memory_response;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        o_stall;
  logic        o_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sa_cache_miss_ctrl #(.ADDR_W(32), .DATA_W(32), .OFFSET_W(6), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .cache_miss(cache_miss), .miss_addr(miss_addr), .evict(evict),
    .evict_addr(evict_addr), .evict_data(evict_data), .o_memory_line(o_memory_line),
    .o_memory_response(o_memory_response), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .o_stall(o_stall), .o_error(o_error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cache_miss = 0; miss_addr = 0; evict = 0; evict_addr = 0; evict_data = 0;
    mem_ack = 0; mem_rdata = 0;
    tick; tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, o_memory_line, o_memory_response, o_stall, o_error} !== '0) begin
      failures++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h line=%h resp=%b stall=%b err=%b, all must be 0",
               mem_req, mem_we, mem_addr, mem_wdata, o_memory_line, o_memory_response, o_stall, o_error);
    end
  endtask

  task automatic test_clean_miss;
    cache_miss = 1; evict = 0; miss_addr = 32'h0000_0004; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (o_stall !== 1'b1) begin failures++; $display("FAIL clean_stall_comb: got %b want 1", o_stall); end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL clean_req: req=%b we=%b addr=%h want 1 0 00000000", mem_req, mem_we, mem_addr);
    end
    tick;
    checks++;
    if (o_memory_response !== 1'b1 || o_memory_line !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL clean_resp: resp=%b line=%h req=%b want 1 deadbeef 0", o_memory_response, o_memory_line, mem_req);
    end
    cache_miss = 0; mem_ack = 0; mem_rdata = 32'h0;
    tick;
    checks++;
    if (o_memory_response !== 1'b0 || o_memory_line !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL clean_resp_once: resp=%b line=%h want 0 deadbeef", o_memory_response, o_memory_line);
    end
    tick; tick;
    checks++;
    if (o_stall !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL clean_idle: stall=%b req=%b want 0 0", o_stall, mem_req);
    end
  endtask

  task automatic test_dirty_miss;
    int resp_cnt = 0;
    cache_miss = 1; evict = 1; evict_addr = 32'h0004_0000; evict_data = 32'h1234_5678;
    miss_addr = 32'h0000_0048;
    tick;
    cache_miss = 0; evict = 0; evict_addr = 32'hFFFF_FFFF; evict_data = 32'hFFFF_FFFF; miss_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0004_0000 || mem_wdata !== 32'h1234_5678) begin
        failures++;
        $display("FAIL dirty_wb cyc%0d: req=%b we=%b addr=%h wdata=%h want 1 1 00040000 12345678",
                 i, mem_req, mem_we, mem_addr, mem_wdata);
      end
      if (i == 3) mem_ack = 1;
      tick;
    end
    mem_ack = 0;
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL dirty_gap: req=%b want 0", mem_req); end
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0040) begin
        failures++;
        $display("FAIL dirty_rd cyc%0d: req=%b we=%b addr=%h want 1 0 00000040", i, mem_req, mem_we, mem_addr);
      end
      if (o_memory_response) resp_cnt++;
      if (i == 3) begin mem_ack = 1; mem_rdata = 32'hCAFE_F00D; end
      tick;
    end
    mem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_memory_response) resp_cnt++;
      if (i == 0) begin
        checks++;
        if (o_memory_line !== 32'hCAFE_F00D) begin
          failures++; $display("FAIL dirty_line: got %h want cafef00d", o_memory_line);
        end
      end
      tick;
    end
    checks++;
    if (resp_cnt != 1) begin failures++; $display("FAIL dirty_resp_count: got %0d want 1", resp_cnt); end
  endtask

  task automatic test_stale_miss;
    cache_miss = 1; evict = 0; miss_addr = 32'h0000_1080; mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    tick;
    tick;
    mem_ack = 0;
    checks++;
    if (o_memory_response !== 1'b1) begin failures++; $display("FAIL stale_resp: got %b want 1", o_memory_response); end
    tick;
    checks++;
    if (mem_req !== 1'b0 || o_stall !== 1'b1) begin
      failures++; $display("FAIL stale_hold: req=%b stall=%b want 0 1", mem_req, o_stall);
    end
    tick;
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL stale_hold_exit: req=%b want 0", mem_req); end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1080) begin
      failures++; $display("FAIL stale_restart: req=%b addr=%h want 1 00001080", mem_req, mem_addr);
    end
    cache_miss = 0; mem_ack = 1;
    tick;
    mem_ack = 0;
    tick; tick; tick;
  endtask

  task automatic test_spurious_ack;
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    tick;
    checks++;
    if (mem_req !== 1'b0 || o_memory_response !== 1'b0 || o_stall !== 1'b0) begin
      failures++; $display("FAIL spur_idle: req=%b resp=%b stall=%b want 0 0 0", mem_req, o_memory_response, o_stall);
    end
    mem_ack = 0;
    cache_miss = 1; evict = 1; evict_addr = 32'h0000_2000; evict_data = 32'h1111_2222; miss_addr = 32'h0000_3004;
    tick;
    cache_miss = 0; evict = 0; mem_ack = 1;
    tick;
    // Gap cycle with ack still asserted: must be ignored.
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL spur_gap_req: req=%b want 0", mem_req); end
    tick;
    mem_ack = 0;
    checks++;
    if (mem_req !== 1'b1 || o_memory_response !== 1'b0 || mem_addr !== 32'h0000_3000) begin
      failures++;
      $display("FAIL spur_gap: req=%b resp=%b addr=%h want 1 0 00003000", mem_req, o_memory_response, mem_addr);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1 || o_memory_response !== 1'b0) begin
      failures++; $display("FAIL spur_wait: req=%b resp=%b want 1 0", mem_req, o_memory_response);
    end
    mem_ack = 1; mem_rdata = 32'h7777_8888;
    tick;
    mem_ack = 0;
    checks++;
    if (o_memory_response !== 1'b1 || o_memory_line !== 32'h7777_8888) begin
      failures++; $display("FAIL spur_resp: resp=%b line=%h want 1 77778888", o_memory_response, o_memory_line);
    end
    tick; tick; tick;
  endtask

  task automatic test_async_reset;
    cache_miss = 1; evict = 0; miss_addr = 32'h0000_4000;
    tick;
    tick;
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL areset_pre: req=%b want 1", mem_req); end
    #2;
    rst = 1'b1; cache_miss = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || o_stall !== 1'b0 || o_memory_response !== 1'b0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL areset: req=%b stall=%b resp=%b addr=%h want 0 0 0 0", mem_req, o_stall, o_memory_response, mem_addr);
    end
    tick;
    rst = 1'b0;
    tick; tick;
    checks++;
    if (mem_req !== 1'b0 || o_memory_response !== 1'b0 || o_stall !== 1'b0) begin
      failures++; $display("FAIL areset_idle: req=%b resp=%b stall=%b want 0 0 0", mem_req, o_memory_response, o_stall);
    end
  endtask

`ifdef MISS_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    cache_miss = 1; evict = 0; miss_addr = 32'h0000_5000; mem_ack = 0;
    tick;
    cache_miss = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem_req !== 1'b1 || o_error !== 1'b0) begin
        failures++; $display("FAIL to_wait cyc%0d: req=%b err=%b want 1 0", i, mem_req, o_error);
      end
      tick;
    end
    checks++;
    if (mem_req !== 1'b0 || o_error !== 1'b1 || o_memory_response !== 1'b1 || o_memory_line !== 32'h0) begin
      failures++;
      $display("FAIL to_fire: req=%b err=%b resp=%b line=%h want 0 1 1 0", mem_req, o_error, o_memory_response, o_memory_line);
    end
    tick; tick; tick; tick;
    checks++;
    if (o_error !== 1'b1 || o_memory_response !== 1'b0) begin
      failures++; $display("FAIL to_sticky: err=%b resp=%b want 1 0", o_error, o_memory_response);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (o_error !== 1'b0) begin failures++; $display("FAIL to_clear: err=%b want 0", o_error); end
    tick;
    rst = 1'b0;
    tick;
  endtask
`else
  task automatic test_no_timeout;
    cache_miss = 1; evict = 0; miss_addr = 32'h0000_5000; mem_ack = 0;
    tick;
    cache_miss = 0;
    for (int i = 0; i < 20; i++) tick;
    checks++;
    if (mem_req !== 1'b1 || o_error !== 1'b0 || o_memory_response !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout: req=%b err=%b resp=%b want 1 0 0", mem_req, o_error, o_memory_response);
    end
    mem_ack = 1; mem_rdata = 32'h0102_0304;
    tick;
    mem_ack = 0;
    checks++;
    if (o_memory_response !== 1'b1 || o_memory_line !== 32'h0102_0304) begin
      failures++; $display("FAIL no_timeout_resp: resp=%b line=%h want 1 01020304", o_memory_response, o_memory_line);
    end
    tick; tick; tick;
  endtask
`endif

  initial begin
    test_reset;
    test_clean_miss;
    test_dirty_miss;
    test_stale_miss;
    test_spurious_ack;
    test_async_reset;
`ifdef MISS_CTRL_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
